dvp_frame_packer: RTL

//  Parametrised successor to the camera capture stage. Assembles DVP byte stream into pixels,

---
 rtl/dvp_frame_packer_if.sv | 33 +++
 rtl/dvp_frame_packer.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/dvp_frame_packer_if.sv
// rtl/dvp_frame_packer_if.sv - camera-side and DDR write-FIFO-side signal bundle for dvp_frame_packer
// TEST_PATTERN_EN adds the test_mode input.
interface dvp_frame_packer_if #(
    parameter int DATA_W = 8,
    parameter int WORD_W = 32
);
    logic              enable;
    logic              dvp_vsync;
    logic              dvp_href;
    logic [DATA_W-1:0] dvp_data;
    logic              fifo_full;
`ifdef TEST_PATTERN_EN
    logic              test_mode;
`endif
    logic              wr_load;
    logic              wr_en;
    logic [WORD_W-1:0] wr_data;
    logic              frame_done;
    logic              ovf_sticky;
    logic [15:0]       frame_cnt;

`ifdef TEST_PATTERN_EN
    modport master (output enable, dvp_vsync, dvp_href, dvp_data, fifo_full, test_mode,
                    input  wr_load, wr_en, wr_data, frame_done, ovf_sticky, frame_cnt);
    modport slave  (input  enable, dvp_vsync, dvp_href, dvp_data, fifo_full, test_mode,
                    output wr_load, wr_en, wr_data, frame_done, ovf_sticky, frame_cnt);
`else
    modport master (output enable, dvp_vsync, dvp_href, dvp_data, fifo_full,
                    input  wr_load, wr_en, wr_data, frame_done, ovf_sticky, frame_cnt);
    modport slave  (input  enable, dvp_vsync, dvp_href, dvp_data, fifo_full,
                    output wr_load, wr_en, wr_data, frame_done, ovf_sticky, frame_cnt);
`endif
endinterface

// File: rtl/dvp_frame_packer.sv
// rtl/dvp_frame_packer.sv - DVP byte stream to cropped, word-packed DDR write-FIFO stream
// Optional TEST_PATTERN_EN: replaces camera pixels with a coordinate pattern when test_mode is set.
module dvp_frame_packer #(
    parameter int DATA_W = 8,
    parameter int PIX_W  = 16,
    parameter int WORD_W = 32,
    parameter int CNT_W  = 12,
    parameter int X_OFF  = 0,
    parameter int Y_OFF  = 0,
    parameter int WIN_W  = 800,
    parameter int WIN_H  = 480
) (
    input  logic              clk,
    input  logic              reset,
    dvp_frame_packer_if.slave bus
);
    localparam int BPP   = PIX_W / DATA_W;
    localparam int PPW   = WORD_W / PIX_W;
    localparam int TOTAL = WIN_W * WIN_H / PPW;
    localparam int PH_W  = (BPP > 1) ? $clog2(BPP) : 1;
    localparam int PC_W  = (PPW > 1) ? $clog2(PPW) : 1;
    localparam int WC_W  = $clog2(TOTAL + 1);

    if (PIX_W % DATA_W != 0) begin : g_chk_pix
        $error("dvp_frame_packer: PIX_W must be a multiple of DATA_W");
    end
    if (WORD_W % PIX_W != 0) begin : g_chk_word
        $error("dvp_frame_packer: WORD_W must be a multiple of PIX_W");
    end
    if ((WIN_W * PIX_W) % WORD_W != 0) begin : g_chk_win
        $error("dvp_frame_packer: WIN_W*PIX_W must be a multiple of WORD_W");
    end
    if ($bits(bus.wr_data) != WORD_W || $bits(bus.dvp_data) != DATA_W) begin : g_chk_if
        $error("dvp_frame_packer: interface widths do not match module parameters");
    end

    typedef enum logic [1:0] {S_IDLE, S_SYNC, S_ACTIVE, S_DONE} state_t;

    state_t            r_state;
    logic              r_vsync_d;
    logic              r_href_d;
    logic [PH_W-1:0]   r_phase;
    logic [CNT_W-1:0]  r_x;
    logic [CNT_W-1:0]  r_y;
    logic [PC_W-1:0]   r_pcnt;
    logic [WC_W-1:0]   r_wcnt;
    logic              r_wr_pend;
    logic [WORD_W-1:0] r_wr_data;
    logic              r_wr_load;
    logic              r_frame_done;
    logic              r_ovf;
    logic [15:0]       r_frame_cnt;

    logic              w_vs_rise;
    logic              w_href_rise;
    logic              w_href_fall;
    logic [PH_W-1:0]   w_phase;
    logic              w_pix_done;
    logic [CNT_W-1:0]  w_x;
    logic              w_in_win;
    logic              w_accept;
    logic              w_start;
    logic              w_word_last;
    logic [PIX_W-1:0]  w_pix_cam;
    logic [PIX_W-1:0]  w_pix_val;
    logic [WORD_W-1:0] w_word_next;

    assign w_vs_rise   = bus.dvp_vsync & ~r_vsync_d;
    assign w_href_rise = bus.dvp_href & ~r_href_d;
    assign w_href_fall = ~bus.dvp_href & r_href_d;
    // Phase and x restart on the href rising edge itself, so the first byte of a line is phase 0.
    assign w_phase     = w_href_rise ? '0 : r_phase;
    assign w_x         = w_href_rise ? '0 : r_x;
    assign w_pix_done  = bus.dvp_href && (w_phase == PH_W'(BPP - 1));
    assign w_in_win    = (32'(w_x) >= 32'(X_OFF)) && (32'(w_x) < 32'(X_OFF + WIN_W)) &&
                         (32'(r_y) >= 32'(Y_OFF)) && (32'(r_y) < 32'(Y_OFF + WIN_H));
    assign w_accept    = (r_state == S_ACTIVE) && w_pix_done && w_in_win;
    assign w_start     = w_vs_rise && bus.enable && ((r_state == S_IDLE) || (r_state == S_ACTIVE));
    assign w_word_last = (r_wcnt == WC_W'(TOTAL - 1));

    if (BPP == 1) begin : g_pix1
        assign w_pix_cam = bus.dvp_data;
    end else begin : g_pixn
        logic [PIX_W-DATA_W-1:0] r_pix_sr;
        always_ff @(posedge clk) begin
            if (reset)             r_pix_sr <= '0;
            else if (bus.dvp_href) r_pix_sr <= w_pix_cam[PIX_W-DATA_W-1:0];
        end
        assign w_pix_cam = {r_pix_sr, bus.dvp_data};
    end

`ifdef TEST_PATTERN_EN
    logic             r_test_mode;
    logic [PIX_W-1:0] w_pix_tp;
    always_ff @(posedge clk) begin
        if (reset)        r_test_mode <= 1'b0;
        else if (w_start) r_test_mode <= bus.test_mode;
    end
    if (PIX_W == 16) begin : g_tp16
        logic [4:0] w_xr5;
        logic [5:0] w_yr6;
        assign w_xr5    = w_x[4:0] - 5'(X_OFF);
        assign w_yr6    = r_y[5:0] - 6'(Y_OFF);
        assign w_pix_tp = {w_xr5, w_yr6, w_xr5};
    end else begin : g_tpx
        assign w_pix_tp = PIX_W'(w_x - CNT_W'(X_OFF));
    end
    assign w_pix_val = r_test_mode ? w_pix_tp : w_pix_cam;
`else
    assign w_pix_val = w_pix_cam;
`endif

    if (PPW == 1) begin : g_word1
        assign w_word_next = w_pix_val;
    end else begin : g_wordn
        logic [WORD_W-PIX_W-1:0] r_word_sr;
        always_ff @(posedge clk) begin
            if (reset)         r_word_sr <= '0;
            else if (w_accept) r_word_sr <= w_word_next[WORD_W-PIX_W-1:0];
        end
        assign w_word_next = {r_word_sr, w_pix_val};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_vsync_d    <= 1'b0;
            r_href_d     <= 1'b0;
            r_phase      <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_pcnt       <= '0;
            r_wcnt       <= '0;
            r_wr_pend    <= 1'b0;
            r_wr_data    <= '0;
            r_wr_load    <= 1'b0;
            r_frame_done <= 1'b0;
            r_ovf        <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_vsync_d    <= bus.dvp_vsync;
            r_href_d     <= bus.dvp_href;
            r_wr_load    <= 1'b0;
            r_frame_done <= 1'b0;
            r_wr_pend    <= 1'b0;

            if (bus.dvp_href) r_phase <= w_pix_done ? '0 : w_phase + 1'b1;

            if (w_pix_done)       r_x <= (w_x == '1) ? w_x : w_x + 1'b1;
            else if (w_href_rise) r_x <= '0;

            if (bus.dvp_vsync)                    r_y <= '0;
            else if (w_href_fall && (r_y != '1)) r_y <= r_y + 1'b1;

            if (w_accept) begin
                r_pcnt <= (r_pcnt == PC_W'(PPW - 1)) ? '0 : r_pcnt + 1'b1;
                if (r_pcnt == PC_W'(PPW - 1)) begin
                    r_wr_pend <= 1'b1;
                    r_wr_data <= w_word_next;
                end
            end

            if (r_wr_pend && bus.fifo_full) r_ovf <= 1'b1;

            case (r_state)
                S_IDLE: ;
                S_SYNC: if (!bus.dvp_vsync) r_state <= S_ACTIVE;
                S_ACTIVE: begin
                    // A vsync rise here is a short frame: abandon it without completion pulses.
                    if (w_vs_rise) begin
                        r_state <= S_IDLE;
                    end else if (r_wr_pend) begin
                        r_wcnt <= r_wcnt + 1'b1;
                        if (w_word_last) begin
                            r_state      <= S_DONE;
                            r_frame_done <= 1'b1;
                            r_frame_cnt  <= r_frame_cnt + 16'd1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase

            if (w_start) begin
                r_state   <= S_SYNC;
                r_wr_load <= 1'b1;
                r_pcnt    <= '0;
                r_wcnt    <= '0;
            end
        end
    end

    assign bus.wr_load    = r_wr_load;
    assign bus.wr_en      = r_wr_pend & ~bus.fifo_full;
    assign bus.wr_data    = r_wr_data;
    assign bus.frame_done = r_frame_done;
    assign bus.ovf_sticky = r_ovf;
    assign bus.frame_cnt  = r_frame_cnt;
endmodule
